sram_bank: RTL

SRAM_BANK -- requirements
Module: sram_bank

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_bank_if.sv | 30 +++
 rtl/sram_word.sv | 40 ++++
 rtl/sram_bank.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bank.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_PULSE  = 2'd2,
    ST_RESP   = 2'd3
  } sram_state_t;

  // Edges from the start of the handshake cycle to rsp_valid.
  localparam int unsigned SRAM_LAT = 3;
  localparam int unsigned BYTE_W   = 8;

endpackage

// File: rtl/sram_bank_if.sv
// Request/response bus of the SRAM bank.
interface sram_bank_if #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DATA_W = 8 * WORD_BYTES;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [WORD_BYTES-1:0] req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sram_word.sv
// One storage word: byte-enabled write on write pulse, gated read on read pulse.
module sram_word
  import sram_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         word_line,
  input  logic                         write_pulse,
  input  logic                         read_pulse,
  input  logic [WORD_BYTES-1:0]        be,
  input  logic [BYTE_W*WORD_BYTES-1:0] wdata,
  output logic [BYTE_W*WORD_BYTES-1:0] rdata_c
);

  logic [WORD_BYTES-1:0][BYTE_W-1:0] mem_q;

  // Byte storage; only enabled bytes change when this word is pulsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (word_line && write_pulse) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem_q[i] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Drive the word onto the shared read bus only while selected and read-pulsed.
  always_comb begin
    rdata_c = '0;
    if (word_line && read_pulse) begin
      rdata_c = mem_q;
    end
  end

endmodule

// File: rtl/sram_bank.sv
// Single-port SRAM bank: one request in flight, IDLE/DECODE/PULSE/RESP sequencing.
module sram_bank
  import sram_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  sram_bank_if.slave  bus
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AEXT_W = ADDR_W + 1;
  localparam int unsigned DATA_W = BYTE_W * WORD_BYTES;

  sram_state_t state_q, state_d;

  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic                  lat_en;

  logic                  wr_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [WORD_BYTES-1:0] be_q;
  logic                  in_range_q;
  logic                  in_range_c;

  logic                  wl_active_c;
  logic                  write_pulse_c;
  logic                  read_pulse_c;
  logic [DEPTH-1:0]      word_line_c;
  logic [DATA_W-1:0]     word_rdata [DEPTH];
  logic [DATA_W-1:0]     rd_word_c;

  assign in_range_c = ({1'b0, bus.req_addr} < AEXT_W'(DEPTH));

  // State and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    lat_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d     = ST_DECODE;
          req_ready_d = 1'b0;
          lat_en      = 1'b1;
        end
      end
      ST_DECODE: begin
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = !in_range_q;
        rsp_rdata_d = (!wr_q && in_range_q) ? rd_word_c : '0;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latch request fields on handshake; bus changes afterwards are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      in_range_q <= 1'b0;
    end else if (lat_en) begin
      wr_q       <= bus.req_write;
      addr_q     <= bus.req_addr;
      wdata_q    <= bus.req_wdata;
      be_q       <= bus.req_be;
      in_range_q <= in_range_c;
    end
  end

  // Word-line decode and single-cycle pulses; out-of-range requests touch nothing.
  always_comb begin
    wl_active_c   = ((state_q == ST_DECODE) || (state_q == ST_PULSE)) && in_range_q;
    write_pulse_c = (state_q == ST_PULSE) && in_range_q && wr_q;
    read_pulse_c  = (state_q == ST_PULSE) && in_range_q && !wr_q;
    word_line_c   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      word_line_c[i] = wl_active_c && (addr_q == ADDR_W'(i));
    end
  end

  // Storage array, one word per address.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    sram_word #(.WORD_BYTES(WORD_BYTES)) u_word (
      .clk         (clk),
      .rst_n       (rst_n),
      .word_line   (word_line_c[g]),
      .write_pulse (write_pulse_c),
      .read_pulse  (read_pulse_c),
      .be          (be_q),
      .wdata       (wdata_q),
      .rdata_c     (word_rdata[g])
    );
  end

  // At most one word drives a non-zero value, so OR-reduce the read bus.
  always_comb begin
    rd_word_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_word_c = rd_word_c | word_rdata[i];
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
